// File: rtl/cpu_pkg.sv
// Shared definitions for the R3000 writeback stage: FSM encoding and default widths.
package cpu_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_DATA_W = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    CANCEL = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry holding register for an ALU result deferred by a colliding load write.
module wb_skid_buffer
  import cpu_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] data
);

  // Entry register; a load wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= in_rd;
      data  <= in_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: merges ALU results and variable-latency load data into one
// registered register-file write per cycle, with load-delay cancellation.
module cpu_writeback
  import cpu_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd,
  output logic              wren_b,
  output logic [REG_AW-1:0] address_b,
  output logic [DATA_W-1:0] data_b
);

  wb_state_t         state_r, state_nxt_s;
  logic [REG_AW-1:0] lrd_r, lrd_nxt_s;
  logic              alu_acc_s, issue_acc_s, cancel_s, load_wr_s;
  logic              skid_valid_s;
  logic [REG_AW-1:0] skid_rd_s;
  logic [DATA_W-1:0] skid_data_s;
  logic              wr_en_s;
  logic [REG_AW-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  assign pend_rd = lrd_r;

  wb_skid_buffer #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (load_wr_s & alu_acc_s),
    .clear   (~load_wr_s & skid_valid_s),
    .in_rd   (alu_rd),
    .in_data (alu_data),
    .valid   (skid_valid_s),
    .rd      (skid_rd_s),
    .data    (skid_data_s)
  );

  // Handshake and acceptance qualifiers.
  always_comb begin
    stall       = skid_valid_s | ((state_r != IDLE) & ld_issue & ~ld_valid);
    alu_acc_s   = alu_valid & ~stall & (alu_rd != REG_AW'(REG_ZERO));
    issue_acc_s = ld_issue & ~stall;
    cancel_s    = alu_acc_s & (state_r == PEND) & (alu_rd == lrd_r);
    load_wr_s   = ld_valid & (state_r == PEND) & ~cancel_s;
  end

  // Next-state logic: a return frees the slot, possibly refilled by a same-cycle issue.
  always_comb begin
    state_nxt_s = state_r;
    lrd_nxt_s   = lrd_r;
    if (ld_valid && (state_r != IDLE)) begin
      if (issue_acc_s && (ld_rd != REG_AW'(REG_ZERO))) begin
        state_nxt_s = PEND;
        lrd_nxt_s   = ld_rd;
      end else begin
        state_nxt_s = IDLE;
      end
    end else if (state_r == IDLE) begin
      if (issue_acc_s && (ld_rd != REG_AW'(REG_ZERO))) begin
        state_nxt_s = PEND;
        lrd_nxt_s   = ld_rd;
      end else begin
        state_nxt_s = IDLE;
      end
    end else if (cancel_s) begin
      state_nxt_s = CANCEL;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Load-tracking FSM with registered pending-load export.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      lrd_r      <= '0;
      pend_valid <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lrd_r      <= lrd_nxt_s;
      pend_valid <= (state_nxt_s == PEND);
    end
  end

  // Write source priority: live load return, then skid entry, then fresh ALU result.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = address_b;
    wr_data_s = data_b;
    if (load_wr_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = lrd_r;
      wr_data_s = ld_data;
    end else if (skid_valid_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = skid_rd_s;
      wr_data_s = skid_data_s;
    end else if (alu_acc_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = alu_rd;
      wr_data_s = alu_data;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Register-file write port registers; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wren_b    <= 1'b0;
      address_b <= '0;
      data_b    <= '0;
    end else begin
      wren_b    <= wr_en_s;
      address_b <= wr_addr_s;
      data_b    <= wr_data_s;
    end
  end

endmodule
